// File: rtl/morse_keyer.sv
// morse_keyer: accepts one ASCII character per valid/ready handshake, looks it
// up in a one-stage registered Morse table and plays the code word out on
// key_out with standard unit timing (dot 1, dash 3, intra gap 1, char gap 3,
// word space 7 units of UNIT_CYCLES clocks).
//
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   char_valid      upstream has a character on char_in
//   char_in   [7:0] ASCII character
//   char_ready      handshake ready (registered)
//   tbl_addr  [7:0] lookup table address, the latched character
//   tbl_data  [7:0] code word {N[2:0], symbols[4:0]}, 1 = dash
//   key_out         Morse key, 1 = mark
//   busy            ~char_ready
module morse_keyer #(
  parameter int unsigned UNIT_CYCLES = 6_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       char_valid,
  input  logic [7:0] char_in,
  output logic       char_ready,
  output logic [7:0] tbl_addr,
  input  logic [7:0] tbl_data,
  output logic       key_out,
  output logic       busy
);

  localparam int unsigned TIMER_W = 24;
  localparam int unsigned UNITS_W = 3;
  localparam int unsigned IDX_W   = 3;
  localparam logic [TIMER_W-1:0] UNIT_LAST = TIMER_W'(UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_MARK,
    S_SPACE,
    S_CHAR_GAP,
    S_WORD_GAP
  } state_t;

  state_t               state_q, state_n;
  logic [7:0]           addr_n;
  logic [7:0]           code_q, code_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic [TIMER_W-1:0]   timer_q, timer_n;
  logic [UNITS_W-1:0]   units_q, units_n;
  logic                 key_n;
  logic                 ready_n;

  logic [2:0]           n_sym;
  logic [IDX_W-1:0]     load_idx;
  logic                 elem_done;
  logic                 accept;

  assign n_sym     = tbl_data[7:5];
  assign load_idx  = IDX_W'(n_sym - 3'd1);
  assign elem_done = (timer_q == UNIT_LAST) && (units_q == UNITS_W'(1));
  assign accept    = char_valid && char_ready;

  // Length in units of a mark for one symbol
  function automatic logic [UNITS_W-1:0] mark_len(input logic dash);
    return dash ? UNITS_W'(3) : UNITS_W'(1);
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tbl_addr   <= '0;
      code_q     <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      units_q    <= '0;
      key_out    <= 1'b0;
      char_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_n;
      tbl_addr   <= addr_n;
      code_q     <= code_n;
      idx_q      <= idx_n;
      timer_q    <= timer_n;
      units_q    <= units_n;
      key_out    <= key_n;
      char_ready <= ready_n;
      busy       <= ~ready_n;
    end
  end

  // Next-state, counters and registered-output values
  always_comb begin
    state_n = state_q;
    addr_n  = tbl_addr;
    code_n  = code_q;
    idx_n   = idx_q;
    key_n   = key_out;
    timer_n = timer_q;
    units_n = units_q;
    ready_n = 1'b0;

    // Unit timer and units-remaining run in every non-idle state
    if (state_q != S_IDLE) begin
      if (timer_q == UNIT_LAST) begin
        timer_n = '0;
        units_n = units_q - UNITS_W'(1);
      end else begin
        timer_n = timer_q + TIMER_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        key_n = 1'b0;
        if (accept) begin
          addr_n  = char_in;
          state_n = S_FETCH;
          timer_n = '0;
          units_n = UNITS_W'(1);
        end
      end
      S_FETCH: begin
        state_n = S_LOAD;
        timer_n = '0;
        units_n = UNITS_W'(1);
      end
      S_LOAD: begin
        timer_n = '0;
        if ((n_sym != 3'd0) && (n_sym <= 3'd5)) begin
          code_n  = tbl_data;
          idx_n   = load_idx;
          key_n   = 1'b1;
          units_n = mark_len(tbl_data[load_idx]);
          state_n = S_MARK;
        end else begin
          key_n   = 1'b0;
          units_n = UNITS_W'(7);
          state_n = S_WORD_GAP;
        end
      end
      S_MARK: begin
        key_n = 1'b1;
        if (elem_done) begin
          key_n   = 1'b0;
          timer_n = '0;
          if (idx_q == '0) begin
            units_n = UNITS_W'(3);
            state_n = S_CHAR_GAP;
          end else begin
            idx_n   = idx_q - IDX_W'(1);
            units_n = UNITS_W'(1);
            state_n = S_SPACE;
          end
        end
      end
      S_SPACE: begin
        key_n = 1'b0;
        if (elem_done) begin
          key_n   = 1'b1;
          timer_n = '0;
          units_n = mark_len(code_q[idx_q]);
          state_n = S_MARK;
        end
      end
      S_CHAR_GAP, S_WORD_GAP: begin
        key_n = 1'b0;
        if (elem_done) begin
          timer_n = '0;
          units_n = UNITS_W'(1);
          if (accept) begin
            addr_n  = char_in;
            state_n = S_FETCH;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        key_n   = 1'b0;
      end
    endcase

    // Ready is raised for the final gap cycle so that a waiting character
    // transfers on the very edge the gap ends, with no idle cycle between.
    ready_n = (state_n == S_IDLE) ||
              (((state_n == S_CHAR_GAP) || (state_n == S_WORD_GAP)) &&
               (units_n == UNITS_W'(1)) && (timer_n == UNIT_LAST));
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Scoreboard bench for morse_keyer: three instances (UNIT_CYCLES 1, 2, 4)
// share a clock; stimulus pushes expected key/ready transitions with their
// absolute cycle numbers, and a negedge monitor pops and compares them.
module tb_morse_keyer;

  localparam logic [1:0] K_RISE = 2'd0;
  localparam logic [1:0] K_FALL = 2'd1;
  localparam logic [1:0] R_RISE = 2'd2;
  localparam logic [1:0] R_FALL = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [29:0] cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] char_valid;
  logic [2:0] char_ready;
  logic [2:0] key_out;
  logic [2:0] busy;
  logic [7:0] char_in  [3];
  logic [7:0] tbl_addr [3];
  logic [7:0] tbl_data [3];

  ev_t        exp_q [3][$];
  int         cyc     = 0;
  int         n_pass  = 0;
  int         n_total = 0;
  bit         mon_en  = 1'b0;
  logic [2:0] key_prev;
  logic [2:0] rdy_prev;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  morse_keyer #(.UNIT_CYCLES(1)) dut_u1 (
    .clk(clk), .rst_n(rst_n[0]), .char_valid(char_valid[0]), .char_in(char_in[0]),
    .char_ready(char_ready[0]), .tbl_addr(tbl_addr[0]), .tbl_data(tbl_data[0]),
    .key_out(key_out[0]), .busy(busy[0]));

  morse_keyer #(.UNIT_CYCLES(2)) dut_u2 (
    .clk(clk), .rst_n(rst_n[1]), .char_valid(char_valid[1]), .char_in(char_in[1]),
    .char_ready(char_ready[1]), .tbl_addr(tbl_addr[1]), .tbl_data(tbl_data[1]),
    .key_out(key_out[1]), .busy(busy[1]));

  morse_keyer #(.UNIT_CYCLES(4)) dut_u4 (
    .clk(clk), .rst_n(rst_n[2]), .char_valid(char_valid[2]), .char_in(char_in[2]),
    .char_ready(char_ready[2]), .tbl_addr(tbl_addr[2]), .tbl_data(tbl_data[2]),
    .key_out(key_out[2]), .busy(busy[2]));

  // Morse lookup table model with one registered stage
  function automatic logic [7:0] lut(input logic [7:0] a);
    case (a)
      8'h45:   return 8'b001_00000;  // E
      8'h41:   return 8'b010_00001;  // A
      8'h54:   return 8'b001_00001;  // T
      8'h30:   return 8'b101_11111;  // 0
      8'h7E:   return 8'b111_11111;  // ~ (N = 7, word space)
      default: return 8'b000_00000;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) tbl_data[d] <= lut(tbl_addr[d]);
  end

  function automatic string kname(input logic [1:0] k);
    case (k)
      K_RISE:  return "key_rise";
      K_FALL:  return "key_fall";
      R_RISE:  return "ready_rise";
      default: return "ready_fall";
    endcase
  endfunction

  task automatic check(input bit ok, input string name, input int d,
                       input string act, input string req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s dut%0d: got %s, required %s", name, d, act, req);
  endtask

  task automatic expect_ev(input int d, input logic [1:0] k, input int at);
    ev_t e;
    e.kind = k;
    e.cyc  = 30'(at);
    exp_q[d].push_back(e);
  endtask

  task automatic observe(input int d, input logic [1:0] k);
    ev_t   e;
    string got;
    got = $sformatf("%s@%0d", kname(k), cyc);
    if (exp_q[d].size() == 0) begin
      check(1'b0, "event", d, got, "no event");
    end else begin
      e = exp_q[d].pop_front();
      check((e.kind == k) && (e.cyc == 30'(cyc)), "event", d, got,
            $sformatf("%s@%0d", kname(e.kind), e.cyc));
      if (e.kind == R_RISE || e.kind == R_FALL)
        check(busy[d] === (e.kind == R_FALL), "busy", d,
              $sformatf("%b", busy[d]), $sformatf("%b", e.kind == R_FALL));
    end
  endtask

  // Monitor: any change on key_out / char_ready is a DUT output event
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (mon_en) begin
        if (key_out[d] !== key_prev[d])
          observe(d, key_out[d] ? K_RISE : K_FALL);
        if (char_ready[d] !== rdy_prev[d])
          observe(d, char_ready[d] ? R_RISE : R_FALL);
      end
    end
    key_prev = key_out;
    rdy_prev = char_ready;
  end

  task automatic wait_until(input int at);
    while (cyc < at) @(negedge clk);
  endtask

  // Single-cycle valid pulse; the DUT is idle so the transfer edge is the next one
  task automatic send(input int d, input logic [7:0] ch);
    char_in[d]    = ch;
    char_valid[d] = 1'b1;
    @(negedge clk);
    char_valid[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    rst_n      = '0;
    char_valid = '0;
    for (int d = 0; d < 3; d++) char_in[d] = 8'h00;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check(key_out[d] === 1'b0, "rst_key", d, $sformatf("%b", key_out[d]), "0");
      check(char_ready[d] === 1'b1, "rst_ready", d, $sformatf("%b", char_ready[d]), "1");
      check(busy[d] === 1'b0, "rst_busy", d, $sformatf("%b", busy[d]), "0");
      check(tbl_addr[d] === 8'h00, "rst_addr", d, $sformatf("%h", tbl_addr[d]), "00");
    end
    rst_n = '1;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);

    // 'E', unit 2: mark E2..E4, ready for transfer at E10
    b = cyc + 1;
    expect_ev(1, R_FALL, b);      expect_ev(1, K_RISE, b + 2);
    expect_ev(1, K_FALL, b + 4);  expect_ev(1, R_RISE, b + 9);
    send(1, "E");
    wait_until(b + 12);

    // 'A', unit 2: dot E2-E4, dash E6-E12, ready at E18
    b = cyc + 1;
    expect_ev(1, R_FALL, b);      expect_ev(1, K_RISE, b + 2);
    expect_ev(1, K_FALL, b + 4);  expect_ev(1, K_RISE, b + 6);
    expect_ev(1, K_FALL, b + 12); expect_ev(1, R_RISE, b + 17);
    send(1, "A");
    wait_until(b + 20);

    // Word spaces (N = 0 and N = 7), unit 2: key stays low, ready at E16
    b = cyc + 1;
    expect_ev(1, R_FALL, b);      expect_ev(1, R_RISE, b + 15);
    send(1, " ");
    wait_until(b + 18);
    b = cyc + 1;
    expect_ev(1, R_FALL, b);      expect_ev(1, R_RISE, b + 15);
    send(1, "~");
    wait_until(b + 18);

    // Back-to-back, unit 1: 'T' then 'E' with valid held high throughout
    b = cyc + 1;
    expect_ev(0, R_FALL, b);      expect_ev(0, K_RISE, b + 2);
    expect_ev(0, K_FALL, b + 5);  expect_ev(0, R_RISE, b + 7);
    expect_ev(0, R_FALL, b + 8);  expect_ev(0, K_RISE, b + 10);
    expect_ev(0, K_FALL, b + 11); expect_ev(0, R_RISE, b + 13);
    char_in[0]    = "T";
    char_valid[0] = 1'b1;
    @(negedge clk);
    check(tbl_addr[0] === 8'h54, "addr_T", 0, $sformatf("%h", tbl_addr[0]), "54");
    char_in[0] = "E";
    wait_until(b + 8);
    char_valid[0] = 1'b0;
    check(tbl_addr[0] === 8'h45, "addr_E", 0, $sformatf("%h", tbl_addr[0]), "45");
    wait_until(b + 16);

    // Reset during a dash, unit 4, then a clean 'E'
    b = cyc + 1;
    expect_ev(2, R_FALL, b);      expect_ev(2, K_RISE, b + 2);
    expect_ev(2, K_FALL, b + 6);  expect_ev(2, R_RISE, b + 6);
    send(2, "T");
    wait_until(b + 5);
    rst_n[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b1;
    @(negedge clk);
    b = cyc + 1;
    expect_ev(2, R_FALL, b);      expect_ev(2, K_RISE, b + 2);
    expect_ev(2, K_FALL, b + 6);  expect_ev(2, R_RISE, b + 17);
    send(2, "E");
    wait_until(b + 20);

    // Digit '0', unit 1: five 3-cycle dashes, 1-cycle gaps, ready at E24
    b = cyc + 1;
    expect_ev(0, R_FALL, b);
    for (int i = 0; i < 5; i++) begin
      expect_ev(0, K_RISE, b + 2 + 4 * i);
      expect_ev(0, K_FALL, b + 5 + 4 * i);
    end
    expect_ev(0, R_RISE, b + 23);
    send(0, "0");
    wait_until(b + 26);

    for (int d = 0; d < 3; d++)
      check(exp_q[d].size() == 0, "drain", d,
            $sformatf("%0d pending", exp_q[d].size()), "0 pending");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/morse_keyer.md
# morse_keyer

Character-to-keying sequencer sitting directly downstream of the Morse lookup table. It accepts one 8-bit ASCII character per handshake and drives the character onto the table address. It then reads back the registered code word one cycle later and plays it out on a single key line using standard Morse unit timing. The key line is the on/off signal for the LED/tone output stage.

## Interface
- UNIT_CYCLES, 6_000_000, clock cycles per Morse time unit (120 ms at 50 MHz); legal range 1 to 2^24-1.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- char_valid  in  1  upstream has a character on char_in.
- char_in  in  8  ASCII character.
- char_ready  out  1  block can accept a character; a transfer occurs on any edge where char_valid && char_ready.
- tbl_addr  out  8  address to the lookup table, equal to the latched character.
- tbl_data  in  8  code word from the lookup table, valid on the second edge after tbl_addr changes (table has one registered stage).
- key_out  out  1  Morse key, 1 = mark (tone/light on).
- busy  out  1  equal to ~char_ready.

## Operation
- Code word format: tbl_data[7:5] = symbol count N; tbl_data[4:0] = symbols.
  - Symbols are sent from bit N-1 down to bit 0; 1 = dash, 0 = dot.
  - N = 0, 6 or 7 means word space.
- Element lengths, in units of UNIT_CYCLES:
  - dot mark 1; dash mark 3.
  - gap between symbols within a character 1.
  - gap after the last symbol of a character 3, measured from the falling edge of key_out.
  - word space 7, key low throughout.
- States:
  - IDLE: char_ready = 1. On a transfer, latch char_in into the address register and go to FETCH.
  - FETCH: one cycle, waiting for the table read. Go to LOAD.
  - LOAD: one cycle; tbl_data is valid.
    - If N is 1..5: capture tbl_data into the code register, set the symbol index to N-1, set key_out = 1 and go to MARK.
    - Otherwise: go to WORD_GAP with key_out = 0.
  - MARK: hold key_out = 1 for 1 or 3 units, according to the current symbol.
    - If the index is 0: go to CHAR_GAP.
    - Otherwise: decrement the index and go to SPACE.
  - SPACE: key_out = 0 for 1 unit, then set key_out = 1 and go to MARK.
  - CHAR_GAP: key_out = 0 for 3 units, then go to IDLE.
  - WORD_GAP: key_out = 0 for 7 units, then go to IDLE.
- Counters:
  - Unit timer counts 0..UNIT_CYCLES-1 and is 24 bits wide.
  - A 3-bit units-remaining counter counts the units of the current element.
  - Both counters are reloaded on every state entry.
- char_in and char_valid are ignored outside IDLE.
- The code register is not re-read from the table during playout.
- All outputs are registered.

## Timing
- Reset values (at the edge where rst_n = 0 is sampled):
  - state IDLE, key_out 0, char_ready 1, busy 0.
  - tbl_addr 0, code register 0, both counters 0.
- Reset mid-operation (any state) has the same effect at the next edge; no partial character is resumed.
- Let E0 be the accepting edge:
  - E0: char_ready falls; tbl_addr updates.
  - E1: the table samples tbl_addr.
  - E2: key_out rises (for a non-space character).
- Each state lasts exactly (units × UNIT_CYCLES) cycles. Symbol duration is exact, with no off-by-one; this is checked at UNIT_CYCLES = 1 and 2.
- Playout duration:
  - Character of total length L units, including its trailing 3-unit gap: char_ready returns to 1 at edge E2 + L·UNIT_CYCLES.
  - Word space: char_ready returns at E2 + 7·UNIT_CYCLES.
- Back-to-back: if char_valid is high when char_ready returns, the transfer happens on that same edge, with zero idle cycles.

## Test plan
- Reset / E, UNIT_CYCLES = 2. Reset, then send 'E' with tbl_data 8'b001_00000. Required: key_out = 0 and char_ready = 1 after reset; key_out high for cycles E2..E4 (2 cycles); char_ready = 1 at E10.
- A. Send 'A' with 8'b010_00001 (dot-dash), UNIT_CYCLES = 2. Required: key_out high E2–E4, low E4–E6, high E6–E12, low from E12; char_ready = 1 at E18.
- Word space. Send ' ' with 8'b000_00000, then a case with 8'b111_11111. Required for both: key_out stays 0; char_ready = 1 at E2 + 14 (UNIT_CYCLES = 2).
- Back-to-back, UNIT_CYCLES = 1. Hold char_valid high across 'T' (8'b001_00001) then 'E'. Required:
  - 'T' mark occupies E2–E5.
  - 'E' is accepted at E8 and its mark rises at E10.
  - char_valid is ignored while busy.
- Reset mid-dash, UNIT_CYCLES = 4. Assert rst_n = 0 for one cycle during a dash. Required: key_out = 0 and char_ready = 1 at the next edge; a new character plays normally afterwards.
- 5-symbol digit '0' (8'b101_11111), UNIT_CYCLES = 1. Required: five 3-cycle marks separated by 1-cycle gaps; char_ready returns 22 cycles after E2.
